// File: rtl/alu_sequencer.sv
// Sequences one matrix-ALU operation per start: latches operands, drives the ALU,
// waits a fixed settle time or for alu_done, then captures result/overflow/error.
module alu_sequencer #(
    parameter int unsigned SETTLE  = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   opcode_in,
    input  logic [7:0]   scalar_in,
    input  logic [199:0] A_in,
    input  logic [199:0] B_in,
    output logic [199:0] alu_A,
    output logic [199:0] alu_B,
    output logic [7:0]   alu_f,
    output logic [2:0]   alu_opcode,
    input  logic [199:0] alu_C,
    input  logic         alu_ovf,
    input  logic         alu_done,
    output logic         busy,
    output logic         done,
    output logic [199:0] result,
    output logic         overflow_flag,
    output logic         error
);

    localparam logic [7:0] SettleLast  = 8'(SETTLE - 1);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e       state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [199:0] a_q, a_d;
    logic [199:0] b_q, b_d;
    logic [7:0]   f_q, f_d;
    logic [2:0]   op_q, op_d;
    logic [199:0] result_q, result_d;
    logic         ovf_q, ovf_d;
    logic         err_q, err_d;
    logic         is_multi;

    // Opcodes 011 (mul) and 111 (determinant) complete on alu_done.
    assign is_multi = op_q[1] & op_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= 8'd0;
            op_q     <= 3'b000;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            f_q      <= f_d;
            op_q     <= op_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        f_d      = f_q;
        op_d     = op_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = A_in;
                    b_d      = B_in;
                    f_d      = scalar_in;
                    op_d     = opcode_in;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = 8'd0;
                    if (opcode_in == 3'b000) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                cnt_d = cnt_q + 8'd1;
                if (is_multi) begin
                    if (alu_done) begin
                        result_d = alu_C;
                        ovf_d    = alu_ovf;
                        state_d  = StDone;
                    end else if (cnt_q == TimeoutLast) begin
                        result_d = '0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b1;
                        state_d  = StDone;
                    end
                end else if (cnt_q == SettleLast) begin
                    result_d = alu_C;
                    ovf_d    = alu_ovf;
                    state_d  = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // The ALU only sees a real opcode while executing, so every operation is an opcode change.
    always_comb begin
        alu_A         = a_q;
        alu_B         = b_q;
        alu_f         = f_q;
        alu_opcode    = (state_q == StExec) ? op_q : 3'b000;
        busy          = (state_q == StExec) || (state_q == StDone);
        done          = (state_q == StDone);
        result        = result_q;
        overflow_flag = ovf_q;
        error         = err_q;
    end

endmodule
